clk_tick_sched: RTL and testbench
=================================

// Module: clk_tick_sched
// PURPOSE
//  Shared timebase scheduler: one prescaler derives BASE_HZ tick from C_50Mhz; NUM_CH channels
//  each emit a 1-cycle clock-enable pulse and a 50% square wave at a runtime-programmed period.
//  Replaces per-consumer free-running dividers (LED blink, debounce, display scan) with one
//  configurable resource programmed over a valid/ready config port.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency, Hz
//  BASE_HZ  1_000       base tick rate; DIV = CLK_HZ/BASE_HZ (integer, >=2)
//  NUM_CH   4           number of channels (1..16)
//  PER_W    16          period field width, in base ticks
// PORTS
//  C_50Mhz     in   1                 system clock
//  rst_n       in   1                 reset: synchronous, active-low
//  cfg_valid   in   1                 config request
//  cfg_ready   out  1                 config accepted when valid&ready
//  cfg_ch      in   $clog2(NUM_CH)+1  target channel
//  cfg_period  in   PER_W             channel period in base ticks
//  cfg_en      in   1                 1=run channel, 0=stop channel
//  cfg_err     out  1                 1-cycle pulse: request rejected (cfg_ch>=NUM_CH)
//  base_tick   out  1                 1-cycle pulse every DIV clocks
//  tick        out  NUM_CH            per-channel 1-cycle enable pulse
//  sq          out  NUM_CH            per-channel square wave, toggles on each tick
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): prescaler=0, all channels OFF, period=1, cnt=0; outputs
//   cfg_ready=1, cfg_err=0, base_tick=0, tick=0, sq=0. Reset mid-config drops pending request.
//  Prescaler: pcnt 0..DIV-1, wraps; base_tick=1 (registered) in cycle pcnt==DIV-1. Never stops.
//  Channel state OFF/RUN. RUN: on base_tick, cnt==period-1 -> cnt=0, tick[i]=1 next cycle,
//   sq[i] toggles; else cnt+1. OFF: cnt held 0, tick[i]=0, sq[i] held 0.
//  Period 0 stored as 1 (tick every base_tick). Period wraps never: cnt is PER_W bits, <period.
//  Config FSM: IDLE (cfg_ready=1) --valid--> APPLY (cfg_ready=0, 1 cycle) --> IDLE.
//   Accept cycle latches ch/period/en; APPLY cycle writes channel: cnt=0, sq=0, state=en?RUN:OFF.
//   Invalid ch: no channel change, cfg_err=1 in APPLY cycle. Max throughput 1 req / 2 clocks.
//  Simultaneous APPLY and base_tick on same channel: APPLY wins, no tick that cycle; first tick
//   after apply occurs after exactly period base_ticks. Other channels unaffected.
//  Reprogramming a RUN channel restarts its phase; in-flight tick pulse already issued completes.
//  All outputs registered; latency base_tick->tick = 1 clock.
// CONFIGURATION
//  CLK_TICK_SCHED_ALIGN_EN defined: FSM adds WAIT between accept and APPLY; APPLY occurs in the
//   cycle base_tick=1, so new config starts on a base-tick boundary; cfg_ready stays 0 from
//   accept until that cycle (up to DIV+1 clocks). Apply-vs-tick rule above still applies.
//  Not defined: APPLY in the cycle after accept, as above (cfg_ready low exactly 1 cycle).
// TESTING  (bench uses CLK_HZ=1000, BASE_HZ=100 -> DIV=10, NUM_CH=4)
//  1 rst_n=0 3 clks, release -> all outputs 0, cfg_ready=1; base_tick first at clk 10, then /10.
//  2 cfg ch0 period=5 en=1 -> tick[0] every 50 clks, sq[0] period 100 clks, 50% duty.
//  3 ch1 period=0 en=1 -> tick[1] on every base_tick (every 10 clks); ch2 period=3 concurrently
//    -> tick[2] every 30 clks, independent.
//  4 cfg ch3 (running) en=0 -> next cycle sq[3]=0, no tick[3]; cfg_ch=7 -> cfg_err 1 pulse, no change.
//  5 apply to ch0 in base_tick cycle -> no tick that cycle, next tick exactly period*10 clks later;
//    back-to-back valid -> cfg_ready toggles 1/0, both requests applied in order.
//  6 rst_n=0 during APPLY/WAIT -> request dropped, state as test 1; ALIGN_EN build: apply lands on
//    base_tick cycle, cfg_ready low until then.

Source files
------------

// File: rtl/clk_tick_sched_if.sv
// Configuration port of clk_tick_sched: valid/ready request carrying channel,
// period and enable, plus a one-cycle reject pulse back to the requester.
interface clk_tick_sched_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned PER_W  = 16
);
  localparam int unsigned CH_W = $clog2(NUM_CH) + 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [PER_W-1:0] cfg_period;
  logic             cfg_en;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_period, cfg_en,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period, cfg_en,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/clk_tick_sched.sv
// Shared timebase: one prescaler makes a base tick every CLK_HZ/BASE_HZ clocks and NUM_CH
// channels divide it into enable pulses and square waves. CLK_TICK_SCHED_ALIGN_EN aligns applies.
module clk_tick_sched #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned BASE_HZ = 1_000,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned PER_W   = 16
) (
  input  logic              C_50Mhz,
  input  logic              rst_n,
  clk_tick_sched_if.slave   cfg,
  output logic              base_tick,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  localparam int unsigned DIV    = CLK_HZ / BASE_HZ;
  localparam int unsigned PCNT_W = $clog2(DIV);
  localparam int unsigned CH_W   = $clog2(NUM_CH) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd2;
`ifdef CLK_TICK_SCHED_ALIGN_EN
  localparam logic [1:0] ST_WAIT  = 2'd1;
`endif

  // prescaler
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              base_tick_q, base_tick_d;

  // config FSM and latched request
  logic [1:0]        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [PER_W-1:0]  period_q, period_d;
  logic              en_q, en_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              accept;
  logic              apply;

  // channels
  logic [NUM_CH-1:0] run_q, run_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sq_q, sq_d;
  logic [PER_W-1:0]  cnt_q [NUM_CH];
  logic [PER_W-1:0]  cnt_d [NUM_CH];
  logic [PER_W-1:0]  per_q [NUM_CH];
  logic [PER_W-1:0]  per_d [NUM_CH];

  // base_tick_d looks at the next count so the registered pulse sits in the pcnt==DIV-1 cycle
  always_comb begin
    pcnt_d      = (pcnt_q == PCNT_W'(DIV - 1)) ? '0 : pcnt_q + PCNT_W'(1);
    base_tick_d = (pcnt_d == PCNT_W'(DIV - 1));
  end

  always_comb begin
    accept   = cfg.cfg_valid && (state_q == ST_IDLE);
    state_d  = state_q;
    ch_d     = ch_q;
    period_d = period_q;
    en_d     = en_q;
    if (accept) begin
      ch_d     = cfg.cfg_ch;
      period_d = (cfg.cfg_period == '0) ? PER_W'(1) : cfg.cfg_period;
      en_d     = cfg.cfg_en;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef CLK_TICK_SCHED_ALIGN_EN
          state_d = ST_WAIT;
`else
          state_d = ST_APPLY;
`endif
        end
      end
`ifdef CLK_TICK_SCHED_ALIGN_EN
      ST_WAIT: begin
        if (base_tick_d) state_d = ST_APPLY;
      end
`endif
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // registered outputs are derived from the next state so they line up with APPLY
    ready_d = (state_d == ST_IDLE);
    err_d   = (state_d == ST_APPLY) && (ch_d >= CH_W'(NUM_CH));
  end

  assign apply = (state_q == ST_APPLY);

  // An apply on a channel overrides any base tick in the same cycle; its counter restarts at 0.
  always_comb begin
    run_d  = run_q;
    sq_d   = sq_q;
    tick_d = '0;
    cnt_d  = cnt_q;
    per_d  = per_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (apply && (ch_q == CH_W'(i))) begin
        run_d[i] = en_q;
        per_d[i] = period_q;
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
      end else if (run_q[i] && base_tick_q) begin
        if (cnt_q[i] == per_q[i] - PER_W'(1)) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          sq_d[i]   = ~sq_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + PER_W'(1);
        end
      end
    end
  end

  always_ff @(posedge C_50Mhz) begin
    if (!rst_n) begin
      pcnt_q      <= '0;
      base_tick_q <= 1'b0;
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      period_q    <= PER_W'(1);
      en_q        <= 1'b0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      run_q       <= '0;
      tick_q      <= '0;
      sq_q        <= '0;
      cnt_q       <= '{default: '0};
      per_q       <= '{default: PER_W'(1)};
    end else begin
      pcnt_q      <= pcnt_d;
      base_tick_q <= base_tick_d;
      state_q     <= state_d;
      ch_q        <= ch_d;
      period_q    <= period_d;
      en_q        <= en_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      run_q       <= run_d;
      tick_q      <= tick_d;
      sq_q        <= sq_d;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;
  assign base_tick     = base_tick_q;
  assign tick          = tick_q;
  assign sq            = sq_q;

endmodule

// File: tb/tb_clk_tick_sched.sv
// Scoreboard bench for clk_tick_sched: a time-arithmetic reference model queues expected
// output events per cycle; a negedge monitor matches them against what the DUT shows.
module tb_clk_tick_sched;
  localparam int DIV = 10;
  localparam int NCH = 4;
  localparam int NS  = 3 + 2 * NCH;

  logic clk = 1'b0;
  logic rst_n;
  logic base_tick;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq;

  clk_tick_sched_if #(.NUM_CH(NCH), .PER_W(16)) bus ();

  clk_tick_sched #(
    .CLK_HZ (1000),
    .BASE_HZ(100),
    .NUM_CH (NCH),
    .PER_W  (16)
  ) dut (
    .C_50Mhz  (clk),
    .rst_n    (rst_n),
    .cfg      (bus),
    .base_tick(base_tick),
    .tick     (tick),
    .sq       (sq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cyc;
    int s;
    bit v;
  } ev_t;
  ev_t evq[$];

  // ---------------- reference model ----------------
  int t_cur = 0;
  int ecount = 0;
  bit m_en[NCH];
  int m_p[NCH];
  int m_a[NCH];
  bit pend = 0;
  int pend_a, pend_ch, pend_p;
  bit pend_en;
  bit rdy_prev = 1'b1;
  bit sq_prev[NCH];

  // number of base-tick cycles in the interval (x, y]
  function automatic int nbase(input int x, input int y);
    return (y + 1) / DIV - (x + 1) / DIV;
  endfunction

  task automatic push(input int s, input bit v);
    ev_t e;
    e.cyc = ecount;
    e.s   = s;
    e.v   = v;
    evq.push_back(e);
  endtask

  initial for (int i = 0; i < NCH; i++) sq_prev[i] = 1'b0;

  always @(posedge clk) begin
    bit rdy, err, bt, tk, sv;
    int n;
    ecount++;
    if (!rst_n) begin
      t_cur = 0;
      pend  = 0;
      for (int i = 0; i < NCH; i++) begin
        m_en[i] = 0;
        m_p[i]  = 1;
        m_a[i]  = -1;
      end
    end else begin
      t_cur++;
      if (pend && t_cur == pend_a + 1) begin
        if (pend_ch < NCH) begin
          m_en[pend_ch] = pend_en;
          m_p[pend_ch]  = pend_p;
          m_a[pend_ch]  = pend_a;
        end
        pend = 0;
      end
      if (bus.cfg_valid && rdy_prev) begin
        pend    = 1;
        pend_ch = int'(bus.cfg_ch);
        pend_p  = (bus.cfg_period == 0) ? 1 : int'(bus.cfg_period);
        pend_en = bus.cfg_en;
`ifdef CLK_TICK_SCHED_ALIGN_EN
        pend_a = t_cur + 1;
        while (pend_a % DIV != DIV - 1) pend_a++;
`else
        pend_a = t_cur;
`endif
      end
    end
    bt  = rst_n && (t_cur % DIV == DIV - 1);
    rdy = !pend;
    err = pend && pend_a == t_cur && pend_ch >= NCH;
    if (bt) push(0, 1'b1);
    if (err) push(1, 1'b1);
    if (rdy != rdy_prev) push(2, rdy);
    rdy_prev = rdy;
    for (int i = 0; i < NCH; i++) begin
      tk = 0;
      sv = 0;
      if (rst_n && m_en[i] && t_cur >= 1) begin
        n  = nbase(m_a[i], t_cur - 1);
        tk = (t_cur - 1 > m_a[i]) && ((t_cur - 1) % DIV == DIV - 1) && (n % m_p[i] == 0);
        sv = ((n / m_p[i]) % 2) != 0;
      end
      if (tk) push(3 + i, 1'b1);
      if (sv != sq_prev[i]) push(3 + NCH + i, sv);
      sq_prev[i] = sv;
    end
  end

  // ---------------- monitor ----------------
  int mcount = 0;
  bit obs_rdy_prev = 1'b1;
  bit obs_sq_prev[NCH];
  initial for (int i = 0; i < NCH; i++) obs_sq_prev[i] = 1'b0;

  function automatic string sname(input int s);
    if (s == 0) return "base_tick";
    if (s == 1) return "cfg_err";
    if (s == 2) return "cfg_ready";
    if (s < 3 + NCH) return $sformatf("tick[%0d]", s - 3);
    return $sformatf("sq[%0d]", s - 3 - NCH);
  endfunction

  always @(negedge clk) begin
    bit exp_ev[NS];
    bit exp_v[NS];
    bit obs_ev[NS];
    bit obs_v[NS];
    ev_t e;
    mcount++;
    for (int s = 0; s < NS; s++) begin
      exp_ev[s] = 0; exp_v[s] = 0; obs_ev[s] = 0; obs_v[s] = 0;
    end
    while (evq.size() > 0 && evq[0].cyc <= mcount) begin
      e = evq.pop_front();
      exp_ev[e.s] = 1;
      exp_v[e.s]  = e.v;
    end
    obs_ev[0] = (base_tick !== 1'b0);   obs_v[0] = 1'b1;
    obs_ev[1] = (bus.cfg_err !== 1'b0); obs_v[1] = 1'b1;
    obs_ev[2] = (bus.cfg_ready !== obs_rdy_prev);
    obs_v[2]  = (bus.cfg_ready === 1'b1);
    obs_rdy_prev = (bus.cfg_ready === 1'b1);
    for (int i = 0; i < NCH; i++) begin
      obs_ev[3 + i]       = (tick[i] !== 1'b0);
      obs_v[3 + i]        = 1'b1;
      obs_ev[3 + NCH + i] = (sq[i] !== obs_sq_prev[i]);
      obs_v[3 + NCH + i]  = (sq[i] === 1'b1);
      obs_sq_prev[i]      = (sq[i] === 1'b1);
    end
    for (int s = 0; s < NS; s++) begin
      if (exp_ev[s] || obs_ev[s]) begin
        total++;
        if (exp_ev[s] != obs_ev[s] || exp_v[s] != obs_v[s]) begin
          bad++;
          $display("FAIL %s cyc=%0d got_event=%0b got_val=%0b want_event=%0b want_val=%0b",
                   sname(s), mcount, obs_ev[s], obs_v[s], exp_ev[s], exp_v[s]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    chk("rst_base_tick", 32'(base_tick), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_sq", 32'(sq), 32'd0);
  endtask

  // called at a negedge; returns at the negedge after the request is accepted
  task automatic send(input int ch, input int per, input bit en);
    int n = 0;
    bus.cfg_valid  = 1'b1;
    bus.cfg_ch     = 3'(ch);
    bus.cfg_period = 16'(per);
    bus.cfg_en     = en;
    while (bus.cfg_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=ready_low want=accept_within_60");
    end
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    bus.cfg_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n          = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_ch     = '0;
    bus.cfg_period = '0;
    bus.cfg_en     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reset_state();
    idle(25);

    send(0, 5, 1); idle(220);
    send(1, 0, 1); send(2, 3, 1); idle(120);
    send(3, 2, 1); idle(60);
    send(3, 2, 0); idle(3);
    send(7, 4, 1); idle(40);

    // land an apply on a base-tick cycle
    n = 0;
    while (!((t_cur % DIV) == DIV - 2 && bus.cfg_ready === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL align_wait got=no_slot want=slot_within_100");
    end
    send(0, 3, 1); idle(80);

    // back-to-back requests with valid held high
    send(1, 4, 1); send(2, 2, 1); idle(100);

    repeat (40) begin
      send($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 3) != 0);
      idle($urandom_range(0, 25));
    end

    // reset while a request is pending
    n = 0;
    while (bus.cfg_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    bus.cfg_valid  = 1'b1;
    bus.cfg_ch     = 3'd0;
    bus.cfg_period = 16'd2;
    bus.cfg_en     = 1'b1;
    @(negedge clk);
    rst_n         = 1'b0;
    bus.cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reset_state();
    idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
